wb_arbiter2: RTL and testbench

WB_ARBITER2 -- requirements
Module: wb_arbiter2

---
 rtl/wb_arbiter2_if.sv | 25 ++
 rtl/wb_arbiter2.sv | 118 +++++++++++
 tb/tb_wb_arbiter2.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter2_if.sv
// One Wishbone B4 pipelined link. The master modport drives the request side.
// The slave modport drives the response side.
interface wb_arbiter2_if;
  logic        cyc;
  logic        stb;
  logic        we;
  logic [31:0] adr;
  logic [31:0] dat_w;
  logic [3:0]  sel;
  logic [31:0] dat_r;
  logic        ack;
  logic        err;
  logic        rty;
  logic        stall;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, err, rty, stall
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err, rty, stall
  );
endinterface

// File: rtl/wb_arbiter2.sv
// Two-master round-robin Wishbone arbiter in front of a single RAM slave.
// It tracks outstanding requests and has a response watchdog.
//
// state  | meaning
// IDLE   | no owner, slave bus quiet, both masters stalled
// GRANT0 | master 0 owns the slave until it drops cyc
// GRANT1 | master 1 owns the slave until it drops cyc
module wb_arbiter2 #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic          clk_bus,
  input  logic          rst_bus,
  wb_arbiter2_if.slave  m0,
  wb_arbiter2_if.slave  m1,
  wb_arbiter2_if.master s
);

  localparam logic [7:0] WDOG_LAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT0 = 2'd1,
    GRANT1 = 2'd2
  } state_t;

  state_t      state;
  logic        last_grant;
  logic [3:0]  outstanding;
  logic [7:0]  wdog;

  logic        g0, g1, granted;
  logic        cyc_g, stb_g, we_g;
  logic [31:0] adr_g, dat_g;
  logic [3:0]  sel_g;
  logic        any_resp, resp_ok, cap, to_fire, accept;

  assign g0      = (state == GRANT0);
  assign g1      = (state == GRANT1);
  assign granted = g0 | g1;

  assign cyc_g = g1 ? m1.cyc   : m0.cyc;
  assign stb_g = g1 ? m1.stb   : m0.stb;
  assign we_g  = g1 ? m1.we    : m0.we;
  assign adr_g = g1 ? m1.adr   : m0.adr;
  assign dat_g = g1 ? m1.dat_w : m0.dat_w;
  assign sel_g = g1 ? m1.sel   : m0.sel;

  // Responses with nothing outstanding are stale and are dropped.
  assign any_resp = s.ack | s.err | s.rty;
  assign resp_ok  = granted && (outstanding != 4'd0) && any_resp;
  assign cap      = (outstanding == 4'hf);
  assign to_fire  = granted && (outstanding != 4'd0) && !any_resp && (wdog == WDOG_LAST);

  // At the cap the strobe is also hidden from the slave so it cannot take it.
  assign s.cyc   = granted & cyc_g & ~to_fire;
  assign s.stb   = granted & stb_g & ~cap & ~to_fire;
  assign s.we    = granted & we_g;
  assign s.adr   = granted ? adr_g : '0;
  assign s.dat_w = granted ? dat_g : '0;
  assign s.sel   = granted ? sel_g : '0;
  assign accept  = s.stb & ~s.stall;

  assign m0.dat_r = g0 ? s.dat_r : '0;
  assign m0.ack   = g0 & resp_ok & s.ack;
  assign m0.err   = g0 & ((resp_ok & s.err) | to_fire);
  assign m0.rty   = g0 & resp_ok & s.rty;
  assign m0.stall = ~g0 | s.stall | cap | to_fire;

  assign m1.dat_r = g1 ? s.dat_r : '0;
  assign m1.ack   = g1 & resp_ok & s.ack;
  assign m1.err   = g1 & ((resp_ok & s.err) | to_fire);
  assign m1.rty   = g1 & resp_ok & s.rty;
  assign m1.stall = ~g1 | s.stall | cap | to_fire;

  always_ff @(posedge clk_bus or negedge rst_bus) begin
    if (!rst_bus) begin
      state       <= IDLE;
      last_grant  <= 1'b1;
      outstanding <= 4'd0;
      wdog        <= 8'd0;
    end else begin
      case (state)
        IDLE: begin
          outstanding <= 4'd0;
          wdog        <= 8'd0;
          if (m0.cyc && (!m1.cyc || last_grant)) begin
            state      <= GRANT0;
            last_grant <= 1'b0;
          end else if (m1.cyc) begin
            state      <= GRANT1;
            last_grant <= 1'b1;
          end
        end
        GRANT0, GRANT1: begin
          if (!cyc_g) begin
            state       <= IDLE;
            outstanding <= 4'd0;
            wdog        <= 8'd0;
          end else if (to_fire) begin
            outstanding <= 4'd0;
            wdog        <= 8'd0;
          end else begin
            if (accept && !resp_ok)
              outstanding <= outstanding + 4'd1;
            else if (!accept && resp_ok)
              outstanding <= outstanding - 4'd1;
            if (resp_ok || outstanding == 4'd0)
              wdog <= 8'd0;
            else
              wdog <= wdog + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wb_arbiter2.sv
// Directed bench for wb_arbiter2. Expectations are queued as each step is driven.
// They are popped in order when the outputs are sampled on the falling edge.
module tb_wb_arbiter2;
  logic clk_bus = 1'b0;
  logic rst_bus = 1'b0;
  always #5 clk_bus = ~clk_bus;

  wb_arbiter2_if a0 ();
  wb_arbiter2_if a1 ();
  wb_arbiter2_if sa ();
  wb_arbiter2_if b0 ();
  wb_arbiter2_if b1 ();
  wb_arbiter2_if tt ();

  wb_arbiter2 dut (.clk_bus(clk_bus), .rst_bus(rst_bus), .m0(a0), .m1(a1), .s(sa));
  wb_arbiter2 #(.TIMEOUT(4)) dut_t (.clk_bus(clk_bus), .rst_bus(rst_bus), .m0(b0), .m1(b1), .s(tt));

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  task automatic push(input string tag, input logic [31:0] v);
    exp_t e;
    e.tag = tag;
    e.val = v;
    sb.push_back(e);
  endtask

  task automatic chk(input logic [31:0] obs);
    exp_t e;
    checks++;
    assert (sb.size() != 0) else begin
      errors++;
      $error("FAIL scoreboard_empty observed %h", obs);
    end
    if (sb.size() != 0) begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        errors++;
        $error("FAIL %s observed %h expected %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic tick();
    @(posedge clk_bus);
    #1;
  endtask

  task automatic smp();
    @(negedge clk_bus);
  endtask

  task automatic clr_master(output logic cyc, output logic stb, output logic we,
                            output logic [31:0] adr, output logic [31:0] dat,
                            output logic [3:0] sel);
    cyc = 0; stb = 0; we = 0; adr = '0; dat = '0; sel = '0;
  endtask

  initial begin
    #200000;
    $display("FAIL sim_timeout");
    $fatal(1, "bench timeout");
  end

  initial begin
    clr_master(a0.cyc, a0.stb, a0.we, a0.adr, a0.dat_w, a0.sel);
    clr_master(a1.cyc, a1.stb, a1.we, a1.adr, a1.dat_w, a1.sel);
    clr_master(b0.cyc, b0.stb, b0.we, b0.adr, b0.dat_w, b0.sel);
    clr_master(b1.cyc, b1.stb, b1.we, b1.adr, b1.dat_w, b1.sel);
    sa.dat_r = '0; sa.ack = 0; sa.err = 0; sa.rty = 0; sa.stall = 0;
    tt.dat_r = '0; tt.ack = 0; tt.err = 0; tt.rty = 0; tt.stall = 0;

    // reset: request and stray response must not leak through
    a0.cyc = 1; a0.stb = 1; a0.adr = 32'h55;
    sa.dat_r = 32'h1234_5678; sa.ack = 1;
    push("rst_s_cyc", 0); push("rst_s_stb", 0); push("rst_s_adr", 0);
    push("rst_m0_stall", 1); push("rst_m1_stall", 1);
    push("rst_m0_ack", 0); push("rst_m0_dat", 0);
    smp();
    chk(sa.cyc); chk(sa.stb); chk(sa.adr);
    chk(a0.stall); chk(a1.stall); chk(a0.ack); chk(a0.dat_r);
    a0.cyc = 0; a0.stb = 0; a0.adr = 0; sa.ack = 0; sa.dat_r = 0;
    tick(); rst_bus = 1; tick();

    // single read from m0
    a0.cyc = 1; a0.stb = 1; a0.adr = 32'h100; a0.sel = 4'hf;
    push("k_s_cyc", 0); push("k_m0_stall", 1);
    smp(); chk(sa.cyc); chk(a0.stall); tick();
    push("k1_s_cyc", 1); push("k1_s_stb", 1); push("k1_s_adr", 32'h100);
    push("k1_m0_stall", 0); push("k1_m1_stall", 1);
    smp(); chk(sa.cyc); chk(sa.stb); chk(sa.adr); chk(a0.stall); chk(a1.stall); tick();
    a0.stb = 0; sa.ack = 1; sa.dat_r = 32'hDEAD_BEEF;
    push("k2_m0_ack", 1); push("k2_m0_dat", 32'hDEAD_BEEF);
    push("k2_m1_stall", 1); push("k2_m1_dat", 0); push("k2_m1_ack", 0);
    smp(); chk(a0.ack); chk(a0.dat_r); chk(a1.stall); chk(a1.dat_r); chk(a1.ack); tick();
    a0.cyc = 0;
    push("stale_ack_m0", 0);
    smp(); chk(a0.ack); tick();
    sa.ack = 0; sa.dat_r = 0;
    push("k4_s_cyc", 0); push("k4_m0_stall", 1);
    smp(); chk(sa.cyc); chk(a0.stall); tick();

    // round robin from a fresh reset
    rst_bus = 0; tick(); rst_bus = 1; tick();
    a0.cyc = 1; a1.cyc = 1;
    push("rr0_m0_stall", 1); push("rr0_m1_stall", 1);
    smp(); chk(a0.stall); chk(a1.stall); tick();
    push("rr1_m0_stall", 0); push("rr1_m1_stall", 1); push("rr1_s_cyc", 1);
    smp(); chk(a0.stall); chk(a1.stall); chk(sa.cyc);
    a0.cyc = 0; tick();
    push("rr2_m0_stall", 1); push("rr2_m1_stall", 1); push("rr2_s_cyc", 0);
    smp(); chk(a0.stall); chk(a1.stall); chk(sa.cyc); tick();
    push("rr3_m1_stall", 0); push("rr3_m0_stall", 1); push("rr3_s_cyc", 1);
    smp(); chk(a1.stall); chk(a0.stall); chk(sa.cyc);
    a1.cyc = 0; tick();
    a0.cyc = 1; a1.cyc = 1;
    push("rr4_s_cyc", 0);
    smp(); chk(sa.cyc); tick();
    push("rr5_m0_stall", 0); push("rr5_m1_stall", 1);
    smp(); chk(a0.stall); chk(a1.stall);
    a0.cyc = 0; a1.cyc = 0; tick(); tick();

    // m1 burst with no slave response: cap at 15 outstanding
    a1.cyc = 1; a1.stb = 1; a1.we = 1; a1.dat_w = 32'h0000_0001;
    sa.dat_r = 32'hA5A5_A5A5;
    tick();
    for (int i = 1; i <= 15; i++) begin
      push("burst_m1_stall", 0);
      smp(); chk(a1.stall); tick();
    end
    push("cap_m1_stall", 1); push("cap_outstanding", 15); push("cap_m0_dat", 0);
    smp(); chk(a1.stall); chk(dut.outstanding); chk(a0.dat_r); tick();
    sa.ack = 1;
    push("cap_m1_ack", 1); push("cap_m0_ack", 0); push("cap_ack_m1_stall", 1);
    smp(); chk(a1.ack); chk(a0.ack); chk(a1.stall); tick();
    sa.ack = 0;
    push("s16_m1_stall", 0);
    smp(); chk(a1.stall); tick();
    a1.stb = 0;
    push("after16_m1_stall", 1); push("after16_outstanding", 15);
    smp(); chk(a1.stall); chk(dut.outstanding);
    a1.cyc = 0; a1.we = 0; sa.dat_r = 0; tick(); tick();

    // simultaneous accept and ack at outstanding 5
    a0.cyc = 1; a0.stb = 1;
    tick();
    for (int i = 0; i < 5; i++) tick();
    sa.ack = 1;
    push("sim_pre_outstanding", 5); push("sim_pre_wdog", 4);
    smp(); chk(dut.outstanding); chk(dut.wdog); tick();
    sa.ack = 0; a0.stb = 0;
    push("sim_outstanding", 5); push("sim_wdog", 0);
    smp(); chk(dut.outstanding); chk(dut.wdog);
    a0.cyc = 0; tick();
    push("leave_outstanding", 0);
    smp(); chk(dut.outstanding); tick();

    // reset in the middle of a burst with 3 outstanding
    a0.cyc = 1; a0.stb = 1; a0.adr = 32'h200;
    tick(); tick(); tick(); tick();
    push("mid_outstanding", 3);
    smp(); chk(dut.outstanding);
    sa.ack = 1; sa.dat_r = 32'hCAFE_F00D;
    rst_bus = 0; #1;
    push("mrst_s_cyc", 0); push("mrst_s_stb", 0); push("mrst_s_adr", 0);
    push("mrst_m0_stall", 1); push("mrst_m0_dat", 0); push("mrst_m0_ack", 0);
    push("mrst_outstanding", 0);
    chk(sa.cyc); chk(sa.stb); chk(sa.adr); chk(a0.stall); chk(a0.dat_r); chk(a0.ack);
    chk(dut.outstanding);
    tick();
    a0.cyc = 0; a0.stb = 0; rst_bus = 1;
    push("late_ack_idle", 0);
    smp(); chk(a0.ack); tick();
    a0.cyc = 1;
    tick();
    push("late_ack_grant", 0); push("late_outstanding", 0);
    smp(); chk(a0.ack); chk(dut.outstanding);
    a0.cyc = 0; sa.ack = 0; sa.dat_r = 0; a0.adr = 0; tick(); tick();

    // watchdog on the TIMEOUT=4 instance
    b0.cyc = 1; b0.stb = 1;
    tick();
    push("to_s_cyc", 1); push("to_m0_stall", 0);
    smp(); chk(tt.cyc); chk(b0.stall); tick();
    b0.stb = 0;
    tick(); tick();
    push("to3_err", 0); push("to3_s_cyc", 1);
    smp(); chk(b0.err); chk(tt.cyc); tick();
    push("to4_err", 1); push("to4_s_cyc", 0); push("to4_ack", 0);
    smp(); chk(b0.err); chk(tt.cyc); chk(b0.ack); tick();
    b0.stb = 1;
    push("to5_err", 0); push("to5_s_cyc", 1); push("to5_outstanding", 0);
    push("to5_m0_stall", 0);
    smp(); chk(b0.err); chk(tt.cyc); chk(dut_t.outstanding); chk(b0.stall); tick();
    b0.stb = 0;
    tick(); tick(); tick();
    tt.ack = 1;
    push("race_ack", 1); push("race_err", 0); push("race_s_cyc", 1);
    smp(); chk(b0.ack); chk(b0.err); chk(tt.cyc); tick();
    tt.ack = 0;
    push("race_outstanding", 0);
    smp(); chk(dut_t.outstanding);
    b0.cyc = 0; tick(); tick();

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_leftover observed %0d expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
